// File: rtl/pong_pkg.sv
// Shared types for the paddle controller: key direction and auto-repeat FSM states.
package pong_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  // Both keys pressed together cancel out.
  function automatic dir_t decode_dir(input logic up, input logic down);
    if (up && !down)      return DIR_UP;
    else if (down && !up) return DIR_DOWN;
    else                  return DIR_NONE;
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Key/width requests in, paddle occupancy and position status out.
interface paddle_ctrl_if #(
  parameter int FIELD = 16,
  parameter int MAX_W = 8
) ();
  localparam int WB = $clog2(MAX_W + 1);
  localparam int PB = $clog2(FIELD);

  logic [WB-1:0]    width;
  logic             up;
  logic             down;
  logic [FIELD-1:0] paddle_o;
  logic [PB-1:0]    pos_o;
  logic             at_top;
  logic             at_bottom;

  modport master (
    output width, up, down,
    input  paddle_o, pos_o, at_top, at_bottom
  );

  modport slave (
    input  width, up, down,
    output paddle_o, pos_o, at_top, at_bottom
  );
endinterface

// File: rtl/paddle_ctrl_key_repeat.sv
// Typematic key repeat: one step on press, a second after DELAY cycles, then one every RATE.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | no key held; a new direction steps at once
// ST_HOLD   | first step taken, counting towards the initial delay
// ST_REPEAT | auto-repeating, one step every RATE cycles
module key_repeat
  import pong_pkg::*;
#(
  parameter int DELAY = 8,
  parameter int RATE  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  dir_t dir,
  output logic step,
  output dir_t step_dir
);

  localparam int CMAX = (DELAY > RATE) ? DELAY : RATE;
  localparam int CW   = $clog2(CMAX + 1);

  rep_state_t    state;
  dir_t          ldir;
  logic [CW-1:0] cnt;

  logic hold_done;
  logic rate_done;

  assign hold_done = (cnt == CW'(DELAY - 1));
  assign rate_done = (cnt == CW'(RATE - 1));

  // Strobe is combinational so the first step lands on the edge the key is first seen.
  always_comb begin
    step     = 1'b0;
    step_dir = dir;
    case (state)
      ST_IDLE:   step = (dir != DIR_NONE);
      ST_HOLD:   step = (dir == ldir) && hold_done;
      ST_REPEAT: step = (dir == ldir) && rate_done;
      default:   step = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      ldir  <= DIR_NONE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dir != DIR_NONE) begin
            ldir  <= dir;
            cnt   <= '0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (dir != ldir) begin
            ldir  <= DIR_NONE;
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (hold_done) begin
            cnt   <= '0;
            state <= ST_REPEAT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_REPEAT: begin
          if (dir != ldir) begin
            ldir  <= DIR_NONE;
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (rate_done) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          ldir  <= DIR_NONE;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position/width register and occupancy mask, stepped by the key_repeat strobe.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int FIELD = 16,
  parameter int MAX_W = 8,
  parameter int DELAY = 8,
  parameter int RATE  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  paddle_ctrl_if.slave  bus
);

  localparam int WB = $clog2(MAX_W + 1);
  localparam int PB = $clog2(FIELD);
  localparam int SW = $clog2(FIELD + 1) + 1;

  logic [WB-1:0] w_eff;
  logic [WB-1:0] w_q;
  logic [PB-1:0] pos_q;
  logic [SW-1:0] end_eff;
  logic [SW-1:0] span;
  logic          step;
  dir_t          step_dir;

  always_comb begin
    w_eff = bus.width;
    if (bus.width == '0)              w_eff = WB'(1);
    else if (bus.width > WB'(MAX_W))  w_eff = WB'(MAX_W);
  end

  assign end_eff = SW'(pos_q) + SW'(w_eff);
  assign span    = SW'(FIELD) - SW'(w_eff);

  key_repeat #(
    .DELAY (DELAY),
    .RATE  (RATE)
  ) u_key_repeat (
    .clk      (clk),
    .reset_n  (reset_n),
    .dir      (decode_dir(bus.up, bus.down)),
    .step     (step),
    .step_dir (step_dir)
  );

  // A width increase that would push the paddle past the bottom wins over any step.
  always_ff @(posedge clk) begin
    w_q <= w_eff;
    if (!reset_n) begin
      pos_q <= PB'(span >> 1);
    end else if (end_eff > SW'(FIELD)) begin
      pos_q <= PB'(span);
    end else if (step) begin
      if (step_dir == DIR_UP && pos_q != '0)
        pos_q <= pos_q - PB'(1);
      else if (step_dir == DIR_DOWN && end_eff < SW'(FIELD))
        pos_q <= pos_q + PB'(1);
    end
  end

  assign bus.paddle_o  = (~({FIELD{1'b1}} << w_q)) << pos_q;
  assign bus.pos_o     = pos_q;
  assign bus.at_top    = (pos_q == '0);
  assign bus.at_bottom = ((SW'(pos_q) + SW'(w_q)) == SW'(FIELD));

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: vector table plus hand-written hold/clamp/reset sequences.
module tb_paddle_ctrl;

  localparam int FIELD = 16;
  localparam int MAX_W = 8;
  localparam int DELAY = 4;
  localparam int RATE  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  paddle_ctrl_if #(.FIELD(FIELD), .MAX_W(MAX_W)) pif ();

  paddle_ctrl #(
    .FIELD (FIELD),
    .MAX_W (MAX_W),
    .DELAY (DELAY),
    .RATE  (RATE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (pif)
  );

  typedef struct {
    logic [3:0] width;
    logic       up;
    logic       down;
    int         cycles;
    int         pos;
    int         mask;
    int         top;
    int         bot;
  } vec_t;

  vec_t vecs[6];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int pos, input int mask, input int top, input int bot);
    check({tag, " pos"},    32'(pif.pos_o),     pos);
    check({tag, " mask"},   32'(pif.paddle_o),  mask);
    check({tag, " top"},    32'(pif.at_top),    top);
    check({tag, " bottom"}, 32'(pif.at_bottom), bot);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int steps;
    int exp_pos;

    vecs[0] = '{width: 4'd4,  up: 1'b1, down: 1'b0, cycles: 1,  pos: 5, mask: 'h01E0, top: 0, bot: 0};
    vecs[1] = '{width: 4'd4,  up: 1'b0, down: 1'b0, cycles: 5,  pos: 5, mask: 'h01E0, top: 0, bot: 0};
    vecs[2] = '{width: 4'd0,  up: 1'b0, down: 1'b0, cycles: 1,  pos: 5, mask: 'h0020, top: 0, bot: 0};
    vecs[3] = '{width: 4'd15, up: 1'b0, down: 1'b0, cycles: 1,  pos: 5, mask: 'h1FE0, top: 0, bot: 0};
    vecs[4] = '{width: 4'd4,  up: 1'b1, down: 1'b1, cycles: 10, pos: 5, mask: 'h01E0, top: 0, bot: 0};
    vecs[5] = '{width: 4'd4,  up: 1'b0, down: 1'b1, cycles: 1,  pos: 6, mask: 'h03C0, top: 0, bot: 0};

    pif.width = 4'd4;
    pif.up    = 1'b0;
    pif.down  = 1'b0;
    reset_n   = 1'b0;
    tick(2);
    reset_n = 1'b1;
    check_all("reset", 6, 'h03C0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      pif.width = vecs[i].width;
      pif.up    = vecs[i].up;
      pif.down  = vecs[i].down;
      tick(vecs[i].cycles);
      check_all($sformatf("vec%0d", i), vecs[i].pos, vecs[i].mask, vecs[i].top, vecs[i].bot);
    end
    pif.up   = 1'b0;
    pif.down = 1'b0;
    tick(1);
    check("release pos", 32'(pif.pos_o), 6);

    // Up held from pos 6: steps at edges 0, DELAY, DELAY+RATE, ... until the top stops it.
    pif.up = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick(1);
      steps   = 1 + ((e >= DELAY) ? ((e - DELAY) / RATE + 1) : 0);
      exp_pos = (6 - steps < 0) ? 0 : 6 - steps;
      check($sformatf("hold_up e%0d pos", e), 32'(pif.pos_o), exp_pos);
    end
    check_all("hold_up end", 0, 'h000F, 1, 0);
    pif.up = 1'b0;
    tick(1);

    // Down held all the way to the bottom (12 steps: edges 0,4,6,...,24).
    pif.down = 1'b1;
    tick(26);
    check_all("hold_down end", 12, 'hF000, 0, 1);

    // Widen at the bottom while still holding down: clamp wins.
    pif.width = 4'd8;
    tick(1);
    check_all("clamp", 8, 'hFF00, 0, 1);

    pif.down  = 1'b0;
    pif.width = 4'd4;
    tick(1);
    check_all("narrow", 8, 'h0F00, 0, 0);

    // Reset asserted at edge 5 of a held down key.
    pif.down = 1'b1;
    tick(1);
    check("rst_seq e0 pos", 32'(pif.pos_o), 9);
    tick(4);
    check("rst_seq e4 pos", 32'(pif.pos_o), 10);
    reset_n = 1'b0;
    tick(1);
    check_all("rst_seq recentre", 6, 'h03C0, 0, 0);
    reset_n = 1'b1;
    tick(1);
    check("rst_seq post pos", 32'(pif.pos_o), 7);
    tick(3);
    check("rst_seq hold pos", 32'(pif.pos_o), 7);
    tick(1);
    check("rst_seq second step", 32'(pif.pos_o), 8);

    // Reversal mid-hold drops to IDLE without stepping, then the new direction steps next edge.
    pif.down = 1'b0;
    pif.up   = 1'b1;
    tick(1);
    check("reverse no step", 32'(pif.pos_o), 8);
    tick(1);
    check("reverse step", 32'(pif.pos_o), 7);
    pif.up = 1'b0;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter FIELD, default 16: paddle field length in cells and paddle_o width.
REQ-002 SHALL have parameter MAX_W, default 8: maximum paddle length in cells, with 1 <= MAX_W <= FIELD.
REQ-003 SHALL have parameter DELAY, default 8: hold cycles from the first step to the second step, >= 1.
REQ-004 SHALL have parameter RATE, default 2: cycles between auto-repeat steps, >= 1.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port width, input, WB = clog2(MAX_W+1) bits: requested paddle length in cells.
REQ-008 SHALL have port up, input, 1 bit: level request to move toward cell 0.
REQ-009 SHALL have port down, input, 1 bit: level request to move toward cell FIELD-1.
REQ-010 SHALL have port paddle_o, output, FIELD bits: occupancy mask, bit i = 1 iff cell i is covered.
REQ-011 SHALL have port pos_o, output, clog2(FIELD) bits: index of the paddle's lowest cell.
REQ-012 SHALL have port at_top, output, 1 bit: 1 iff pos_o == 0.
REQ-013 SHALL have port at_bottom, output, 1 bit: 1 iff pos_o + w_q == FIELD.

Function
REQ-014 SHALL compute the effective width w_eff as: width == 0 gives 1; width > MAX_W gives MAX_W; otherwise width.
REQ-015 SHALL register w_eff into w_q every cycle.
REQ-016 SHALL drive paddle_o, pos_o, at_top and at_bottom combinationally from pos_q and w_q only, with no path from any input.
REQ-017 SHALL set paddle_o[i] = 1 exactly for pos_q <= i < pos_q + w_q.
REQ-018 SHALL decode dir as UP for up & ~down, DOWN for down & ~up, and NONE otherwise (both high counts as NONE).
REQ-019 SHALL implement an FSM with states IDLE, HOLD and REPEAT, plus a latched direction ldir and a counter cnt.
REQ-020 SHALL, in IDLE with dir != NONE, take one step, latch ldir = dir, clear cnt and enter HOLD.
REQ-021 SHALL, in IDLE with dir == NONE, remain in IDLE.
REQ-022 SHALL, in HOLD or REPEAT with dir != ldir (release, reversal or both high), enter IDLE that cycle without stepping.
REQ-023 SHALL, in HOLD with dir == ldir, increment cnt; when cnt == DELAY-1 it SHALL step, clear cnt and enter REPEAT.
REQ-024 SHALL, in REPEAT with dir == ldir, increment cnt; when cnt == RATE-1 it SHALL step and clear cnt.
REQ-025 SHALL, for a held key first sampled at edge 0, step at edges 0, DELAY, DELAY+RATE, DELAY+2*RATE, and so on.
REQ-026 SHALL, on an UP step, set pos_q to pos_q-1 only if pos_q > 0.
REQ-027 SHALL, on a DOWN step, set pos_q to pos_q+1 only if pos_q + w_eff < FIELD.
REQ-028 SHALL, on a step at a limit, leave pos_q unchanged while the FSM still advances.
REQ-029 SHALL, when pos_q + w_eff > FIELD, set pos_q to FIELD - w_eff; this clamp has priority and any step that cycle is discarded.
REQ-030 SHALL never wrap: pos_q stays in 0..FIELD-w_q at all times, and paddle_o never wraps around the field ends.
REQ-031 SHALL size cnt to clog2(max(DELAY,RATE)+1) bits.

Reset
REQ-032 SHALL, with reset_n low at a clock edge, set w_q = w_eff, pos_q = (FIELD - w_eff) / 2 (floor), state = IDLE, ldir = NONE and cnt = 0.
REQ-033 SHALL give reset priority over all other activity, including reset asserted mid-HOLD or mid-REPEAT.
REQ-034 SHALL treat the first cycle after reset as IDLE, so a key already held then steps immediately.

Structure
REQ-035 SHALL place the dir and FSM state enumerations in the shared package pong_pkg.
REQ-036 SHALL put the IDLE/HOLD/REPEAT FSM and cnt in sub-module key_repeat (inputs: dir; output: one-cycle step strobe plus direction); paddle_ctrl SHALL hold position, width and mask logic.

Verification (FIELD=16, MAX_W=8, DELAY=4, RATE=2)
REQ-037 SHALL cover: reset with width=4 -> pos_o=6, paddle_o=0x03C0, at_top=0, at_bottom=0.
REQ-038 SHALL cover: from pos 6 w=4, up high for 1 cycle -> pos_o=5, paddle_o=0x01E0, no further steps.
REQ-039 SHALL cover: from pos 6, up held 14 cycles -> steps at edges 0,4,6,8,10,12 -> pos_o=0, paddle_o=0x000F, at_top=1, no change at edge 14.
REQ-040 SHALL cover: pos 12 w=4 (at_bottom=1), width set to 8 while down held -> next cycle pos_o=8, paddle_o=0xFF00, at_bottom=1.
REQ-041 SHALL cover: up and down both high for 10 cycles -> pos_o unchanged, FSM stays IDLE; separately, width=0 -> 1-cell paddle, and width=15 -> 8-cell paddle.
REQ-042 SHALL cover: reset_n low at edge 5 of a held down -> pos_o recentres to 6 (w=4); down still held -> step at the first post-reset edge.
